pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: max consecutive dmem not-ready cycles before timeout (1..255).
REQ-002 SHALL have parameter CNT_W, default 32: stall performance counter width.
REQ-003 SHALL have port in_clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port in_rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports in_id_rs_addr / in_id_rt_addr, input, 5 each: source registers of the instruction in ID.
REQ-006 SHALL have ports in_id_uses_rs / in_id_uses_rt, input, 1 each: the ID instruction reads rs / rt.
REQ-007 SHALL have ports in_ex_dmem_ena, in_ex_dmem_wena, in_ex_rd_wena, input, 1 each; and in_ex_rd_waddr, input, 5: ID/EX outputs.
REQ-008 SHALL have ports in_mem_dmem_ena, input, 1: EX/MEM out_dmem_ena; and in_dmem_ready, input, 1: data memory access complete.
REQ-009 SHALL have port in_branch_taken, input, 1: taken branch or jump resolved in EX.
REQ-010 SHALL have outputs out_pc_stall, out_if_id_stall, out_id_ex_stall, out_ex_mem_stall, each 1: hold the register.
REQ-011 SHALL have outputs out_if_id_flush, out_id_ex_flush, out_mem_wb_bubble, each 1: load a bubble (all enables 0).
REQ-012 SHALL have outputs out_mem_timeout, 1: sticky error; out_state, 2: FSM state; out_stall_cycles, CNT_W: stall counter.

Function
REQ-013 SHALL implement FSM states RUN=2'd0, MEM_WAIT=2'd1, TIMEOUT=2'd2; 2'd3 is unreachable and SHALL return to RUN.
REQ-014 mem_busy = in_mem_dmem_ena & ~in_dmem_ready; in RUN or MEM_WAIT, mem_busy SHALL assert all four stalls plus out_mem_wb_bubble in that same cycle (combinational).
REQ-015 RUN -> MEM_WAIT on mem_busy; MEM_WAIT -> RUN on ~mem_busy; the wait counter SHALL reset to 0 on any transition into RUN.
REQ-016 The wait counter SHALL increment in each MEM_WAIT cycle with mem_busy; when it reaches WAIT_MAX with mem_busy still high, the FSM SHALL go to TIMEOUT.
REQ-017 TIMEOUT SHALL assert all stalls and out_mem_wb_bubble and SHALL set out_mem_timeout; it is left only by reset.
REQ-018 Load-use hazard: in_ex_dmem_ena & ~in_ex_dmem_wena & in_ex_rd_wena & in_ex_rd_waddr!=0 & ((in_id_uses_rs & rs==waddr) | (in_id_uses_rt & rt==waddr)).
REQ-019 A load-use hazard with no mem stall SHALL assert out_pc_stall, out_if_id_stall and out_id_ex_flush for one cycle; the hazard clears once the load moves on.
REQ-020 in_branch_taken with no mem stall SHALL assert out_if_id_flush and out_id_ex_flush; a load-use stall SHALL be suppressed in the same cycle.
REQ-021 Priority SHALL be TIMEOUT > mem stall > branch > load-use; flushes SHALL never assert while any stall from REQ-014 or REQ-017 is active.
REQ-022 A branch held during a mem stall SHALL take effect in the first cycle after release, because EX stays frozen.
REQ-023 out_stall_cycles SHALL increment by 1 in every cycle where out_pc_stall=1 and SHALL wrap at 2^CNT_W.
REQ-024 Stall, flush and bubble outputs are combinational; out_state, out_mem_timeout and out_stall_cycles are registered.

Reset
REQ-025 While in_rst=1, all outputs SHALL be 0 and stall/flush outputs SHALL be forced to 0.
REQ-026 At the first in_clk edge with in_rst=1, the state SHALL become RUN and the wait counter, out_stall_cycles and out_mem_timeout SHALL become 0.
REQ-027 Reset mid-MEM_WAIT or in TIMEOUT SHALL return to RUN with no residual stall.

Structure
REQ-028 Package pipe_ctrl_pkg SHALL hold the state encodings and the WAIT_MAX/CNT_W defaults.
REQ-029 Sub-module pipe_load_use_detect SHALL implement REQ-018 combinationally and output a single hazard bit.

Verification
REQ-030 EX lw $8, ID add $9,$8,$1 with uses_rs=1 -> one cycle of pc/if_id stall plus id_ex flush; next cycle no hazard; out_stall_cycles=1.
REQ-031 EX lw $0, ID reads $0 -> no stall and no flush.
REQ-032 in_mem_dmem_ena=1 and in_dmem_ready=0 for 3 cycles, then 1 -> all stalls high for 3 cycles, out_state=1 during the wait, then RUN; counter=3.
REQ-033 in_dmem_ready held 0 with WAIT_MAX=15 -> TIMEOUT and out_mem_timeout=1 after 16 busy cycles; sync reset -> RUN and all outputs 0.
REQ-034 in_branch_taken during a 2-cycle mem stall -> no flush for 2 cycles, then if_id and id_ex flush in the release cycle.
REQ-035 Branch plus load-use in the same cycle -> flushes only, no pc stall.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings and
// default sizing for the memory-wait timeout and stall counter.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_TIMEOUT  = 2'd2,
      ST_UNUSED   = 2'd3
   } ctrl_state_t;

   localparam int WAIT_MAX_DEF = 15;
   localparam int CNT_W_DEF    = 32;

endpackage

// File: rtl/pipe_load_use_detect.sv
// Flags an instruction in ID that needs a value still being loaded by the
// instruction in EX; register $0 never creates a dependency.
module pipe_load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic       in_ex_dmem_ena,
   input  logic       in_ex_dmem_wena,
   input  logic       in_ex_rd_wena,
   input  logic [4:0] in_ex_rd_waddr,
   input  logic [4:0] in_id_rs_addr,
   input  logic [4:0] in_id_rt_addr,
   input  logic       in_id_uses_rs,
   input  logic       in_id_uses_rt,
   output logic       out_hazard
);

   logic ex_is_load;
   logic rs_match;
   logic rt_match;

   always_comb begin
      ex_is_load = in_ex_dmem_ena & ~in_ex_dmem_wena & in_ex_rd_wena & (in_ex_rd_waddr != 5'd0);
      rs_match   = in_id_uses_rs & (in_id_rs_addr == in_ex_rd_waddr);
      rt_match   = in_id_uses_rt & (in_id_rt_addr == in_ex_rd_waddr);
      out_hazard = ex_is_load & (rs_match | rt_match);
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: freezes the pipe on slow data memory,
// squashes wrong-path fetches on taken branches, and inserts load-use bubbles.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int WAIT_MAX = WAIT_MAX_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic             in_clk,
   input  logic             in_rst,
   input  logic [4:0]       in_id_rs_addr,
   input  logic [4:0]       in_id_rt_addr,
   input  logic             in_id_uses_rs,
   input  logic             in_id_uses_rt,
   input  logic             in_ex_dmem_ena,
   input  logic             in_ex_dmem_wena,
   input  logic             in_ex_rd_wena,
   input  logic [4:0]       in_ex_rd_waddr,
   input  logic             in_mem_dmem_ena,
   input  logic             in_dmem_ready,
   input  logic             in_branch_taken,
   output logic             out_pc_stall,
   output logic             out_if_id_stall,
   output logic             out_id_ex_stall,
   output logic             out_ex_mem_stall,
   output logic             out_if_id_flush,
   output logic             out_id_ex_flush,
   output logic             out_mem_wb_bubble,
   output logic             out_mem_timeout,
   output logic [1:0]       out_state,
   output logic [CNT_W-1:0] out_stall_cycles
);

   localparam logic [8:0] WAIT_LIM = 9'(WAIT_MAX);

   ctrl_state_t state_q, state_d;
   logic [7:0]  wait_q, wait_d;
   logic [8:0]  wait_inc;
   logic        mem_busy;
   logic        load_use;
   logic        hold_all;

   pipe_load_use_detect u_load_use (
      .in_ex_dmem_ena (in_ex_dmem_ena),
      .in_ex_dmem_wena(in_ex_dmem_wena),
      .in_ex_rd_wena  (in_ex_rd_wena),
      .in_ex_rd_waddr (in_ex_rd_waddr),
      .in_id_rs_addr  (in_id_rs_addr),
      .in_id_rt_addr  (in_id_rt_addr),
      .in_id_uses_rs  (in_id_uses_rs),
      .in_id_uses_rt  (in_id_uses_rt),
      .out_hazard     (load_use)
   );

   assign mem_busy = in_mem_dmem_ena & ~in_dmem_ready;
   assign wait_inc = {1'b0, wait_q} + 9'd1;

   // The wait count tracks busy cycles after the first; the limit trips on the
   // busy cycle that would take it to WAIT_MAX.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         ST_RUN: begin
            wait_d = 8'd0;
            if (mem_busy) state_d = ST_MEM_WAIT;
         end
         ST_MEM_WAIT: begin
            if (!mem_busy) begin
               state_d = ST_RUN;
               wait_d  = 8'd0;
            end else begin
               wait_d = wait_inc[7:0];
               if (wait_inc >= WAIT_LIM) state_d = ST_TIMEOUT;
            end
         end
         ST_TIMEOUT: state_d = ST_TIMEOUT;
         default: begin
            state_d = ST_RUN;
            wait_d  = 8'd0;
         end
      endcase
   end

   // Memory freeze outranks branch, which outranks load-use; a frozen EX keeps
   // any pending branch until the freeze lifts.
   always_comb begin
      hold_all          = 1'b0;
      out_pc_stall      = 1'b0;
      out_if_id_stall   = 1'b0;
      out_id_ex_stall   = 1'b0;
      out_ex_mem_stall  = 1'b0;
      out_if_id_flush   = 1'b0;
      out_id_ex_flush   = 1'b0;
      out_mem_wb_bubble = 1'b0;
      if (!in_rst && state_q != ST_UNUSED) begin
         hold_all = (state_q == ST_TIMEOUT) | mem_busy;
         if (hold_all) begin
            out_pc_stall      = 1'b1;
            out_if_id_stall   = 1'b1;
            out_id_ex_stall   = 1'b1;
            out_ex_mem_stall  = 1'b1;
            out_mem_wb_bubble = 1'b1;
         end else if (in_branch_taken) begin
            out_if_id_flush = 1'b1;
            out_id_ex_flush = 1'b1;
         end else if (load_use) begin
            out_pc_stall    = 1'b1;
            out_if_id_stall = 1'b1;
            out_id_ex_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_q          <= ST_RUN;
         wait_q           <= 8'd0;
         out_mem_timeout  <= 1'b0;
         out_stall_cycles <= '0;
      end else begin
         state_q         <= state_d;
         wait_q          <= wait_d;
         out_mem_timeout <= (state_d == ST_TIMEOUT);
         if (out_pc_stall) out_stall_cycles <= out_stall_cycles + CNT_W'(1);
      end
   end

   assign out_state = state_q;

endmodule
